effect_scheduler: RTL and testbench

- Sequences and shares the 7-digit 7-segment display between up to NUM_EFFECTS effect engines.
- Generates the 3-bit effect enable code and the 2-bit frequency select that all effect engines decode.
- Muxes the selected engine's digit-select (trans) and segment (led7seg) buses to the panel, and inserts a blanked gap on every effect change.
- Advances the effect on a user button press, or automatically after a dwell time.

---
 rtl/effect_scheduler_if.sv | 33 +++
 rtl/effect_scheduler.sv | 118 +++++++++++
 tb/tb_effect_scheduler.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/effect_scheduler_if.sv
// Panel/engine bus bundle for the effect scheduler.
// master: scheduler side; slave: engines/panel side.
interface effect_scheduler_if #(
  parameter int NUM_EFFECTS = 5
);
  logic [7*NUM_EFFECTS-1:0] trans_bus;
  logic [7*NUM_EFFECTS-1:0] seg_bus;
  logic [2:0]               enable;
  logic [1:0]               frequency;
  logic [6:0]               trans;
  logic [6:0]               led7seg;
  logic [2:0]               effect_idx;

  modport master (
    input  trans_bus,
    input  seg_bus,
    output enable,
    output frequency,
    output trans,
    output led7seg,
    output effect_idx
  );

  modport slave (
    output trans_bus,
    output seg_bus,
    input  enable,
    input  frequency,
    input  trans,
    input  led7seg,
    input  effect_idx
  );
endinterface

// File: rtl/effect_scheduler.sv
// Shares a 7-digit 7-seg panel between effect engines, blanking on change.
// Ports: clk, rst, btn_next, btn_speed, auto_mode, bus (master modport).
module effect_scheduler #(
  parameter int NUM_EFFECTS = 5,
  parameter int TICK_DIV    = 25000000,
  parameter int DWELL_TICKS = 16,
  parameter int BLANK_TICKS = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_next,
  input  logic btn_speed,
  input  logic auto_mode,
  effect_scheduler_if.master bus
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam int BW = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;

  localparam logic [0:0] S_BLANK = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  logic [0:0]    state, state_n;
  logic [2:0]    idx, idx_n, idx_inc;
  logic [TW-1:0] tick_cnt;
  logic [DW-1:0] dwell_cnt, dwell_n;
  logic [BW-1:0] blank_cnt, blank_n;
  logic          next_q, speed_q;
  logic          tick, next_edge, speed_edge, adv;
  logic [6:0]    trans_sel, seg_sel;

  assign tick       = (tick_cnt == TW'(TICK_DIV - 1));
  assign next_edge  = btn_next & ~next_q;
  assign speed_edge = btn_speed & ~speed_q;
  assign idx_inc    = (idx == 3'(NUM_EFFECTS)) ? 3'd1 : idx + 3'd1;
  assign adv        = next_edge |
                      (auto_mode & tick &
                       (dwell_cnt == DW'(DWELL_TICKS - 1)));

  always_comb begin
    state_n = state;
    idx_n   = idx;
    blank_n = blank_cnt;
    dwell_n = dwell_cnt;
    if (state == S_BLANK) begin
      // A press wins over a coinciding blank expiry.
      if (next_edge) begin
        idx_n   = idx_inc;
        blank_n = '0;
      end else if (tick) begin
        if (blank_cnt == BW'(BLANK_TICKS - 1)) begin
          state_n = S_RUN;
          blank_n = '0;
          dwell_n = '0;
        end else begin
          blank_n = blank_cnt + 1'b1;
        end
      end
    end else begin
      if (!auto_mode) dwell_n = '0;
      else if (tick)  dwell_n = dwell_cnt + 1'b1;
      if (adv) begin
        idx_n   = idx_inc;
        state_n = S_BLANK;
        blank_n = '0;
        dwell_n = '0;
      end
    end
  end

  // Look ahead to the next selection so enable and panel switch together.
  always_comb begin
    trans_sel = 7'h7F;
    seg_sel   = 7'h7F;
    for (int k = 0; k < NUM_EFFECTS; k++) begin
      if (idx_n == 3'(k + 1)) begin
        trans_sel = bus.trans_bus[7*k +: 7];
        seg_sel   = bus.seg_bus[7*k +: 7];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_BLANK;
      idx            <= 3'd1;
      tick_cnt       <= '0;
      dwell_cnt      <= '0;
      blank_cnt      <= '0;
      next_q         <= 1'b1;
      speed_q        <= 1'b1;
      bus.enable     <= 3'd0;
      bus.frequency  <= 2'b00;
      bus.trans      <= 7'h7F;
      bus.led7seg    <= 7'h7F;
      bus.effect_idx <= 3'd1;
    end else begin
      state          <= state_n;
      idx            <= idx_n;
      tick_cnt       <= tick ? '0 : tick_cnt + 1'b1;
      dwell_cnt      <= dwell_n;
      blank_cnt      <= blank_n;
      next_q         <= btn_next;
      speed_q        <= btn_speed;
      bus.effect_idx <= idx_n;
      if (speed_edge) bus.frequency <= bus.frequency + 2'd1;
      if (state_n == S_RUN) begin
        bus.enable  <= idx_n;
        bus.trans   <= trans_sel;
        bus.led7seg <= seg_sel;
      end else begin
        bus.enable  <= 3'd0;
        bus.trans   <= 7'h7F;
        bus.led7seg <= 7'h7F;
      end
    end
  end
endmodule

// File: tb/tb_effect_scheduler.sv
// Directed bench for effect_scheduler (5 effects, short tick/dwell/blank).
// Cycle c is the c-th clock after reset release.
module tb_effect_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_next = 1'b0;
  logic btn_speed = 1'b0;
  logic auto_mode = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   seq [5] = '{2, 3, 4, 5, 1};

  effect_scheduler_if #(.NUM_EFFECTS(5)) bus ();

  effect_scheduler #(
    .NUM_EFFECTS(5),
    .TICK_DIV(4),
    .DWELL_TICKS(3),
    .BLANK_TICKS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_next(btn_next),
    .btn_speed(btn_speed),
    .auto_mode(auto_mode),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic press_next();
    btn_next = 1'b1;
    step();
    btn_next = 1'b0;
    step();
  endtask

  task automatic wait_enable(input logic [2:0] exp, input int budget);
    int n = 0;
    while (bus.enable !== exp && n < budget) begin
      step();
      n++;
    end
    check("wait_enable", 8'(bus.enable), 8'(exp));
  endtask

  initial begin
    bus.trans_bus = '0;
    bus.seg_bus   = '0;
    repeat (3) step();
    rst = 1'b0;
    cyc = 0;

    check("rst_enable", 8'(bus.enable), 8'd0);
    check("rst_trans", 8'(bus.trans), 8'h7F);
    check("rst_seg", 8'(bus.led7seg), 8'h7F);
    check("rst_idx", 8'(bus.effect_idx), 8'd1);
    check("rst_freq", 8'(bus.frequency), 8'd0);
    goto(7);
    check("c7_enable", 8'(bus.enable), 8'd0);
    goto(8);
    check("c8_enable", 8'(bus.enable), 8'd1);

    press_next();
    press_next();
    goto(15);
    check("to3_blank", 8'(bus.enable), 8'd0);
    goto(16);
    check("to3_run", 8'(bus.enable), 8'd3);
    check("mux_pre", 8'(bus.trans), 8'h00);
    bus.trans_bus[20:14] = 7'b1101111;
    bus.seg_bus[20:14]   = 7'b1000000;
    step();
    check("mux_trans", 8'(bus.trans), 8'h6F);
    check("mux_seg", 8'(bus.led7seg), 8'h40);
    bus.trans_bus[13:7] = 7'h55;
    bus.seg_bus[13:7]   = 7'h2A;
    step();
    check("mux_s2_trans", 8'(bus.trans), 8'h6F);
    check("mux_s2_seg", 8'(bus.led7seg), 8'h40);

    press_next();
    press_next();
    goto(28);
    check("at5", 8'(bus.enable), 8'd5);
    btn_next = 1'b1;
    step();
    btn_next = 1'b0;
    check("wrap_enable", 8'(bus.enable), 8'd0);
    check("wrap_trans", 8'(bus.trans), 8'h7F);
    check("wrap_seg", 8'(bus.led7seg), 8'h7F);
    check("wrap_idx", 8'(bus.effect_idx), 8'd1);
    goto(35);
    check("wrap_blank", 8'(bus.enable), 8'd0);
    goto(36);
    check("wrap_run", 8'(bus.enable), 8'd1);
    goto(76);
    check("persist", 8'(bus.enable), 8'd1);

    auto_mode = 1'b1;
    goto(87);
    check("auto_last", 8'(bus.enable), 8'd1);
    goto(88);
    check("auto_blank", 8'(bus.enable), 8'd0);
    for (int k = 0; k < 5; k++) begin
      goto(95 + 20 * k);
      check("auto_gap", 8'(bus.enable), 8'd0);
      goto(96 + 20 * k);
      check("auto_run", 8'(bus.enable), 8'(seq[k]));
    end

    goto(207);
    check("col_pre", 8'(bus.enable), 8'd2);
    btn_next = 1'b1;
    step();
    btn_next = 1'b0;
    check("col_dwell_idx", 8'(bus.effect_idx), 8'd3);
    goto(216);
    check("col_dwell_run", 8'(bus.enable), 8'd3);
    goto(235);
    check("col_blank_pre", 8'(bus.effect_idx), 8'd4);
    btn_next = 1'b1;
    step();
    btn_next = 1'b0;
    check("col_blank_en", 8'(bus.enable), 8'd0);
    check("col_blank_idx", 8'(bus.effect_idx), 8'd5);
    goto(243);
    check("col_restart", 8'(bus.enable), 8'd0);
    goto(244);
    check("col_run", 8'(bus.enable), 8'd5);

    auto_mode = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      btn_speed = 1'b1;
      step();
      btn_speed = 1'b0;
      check("speed", 8'(bus.frequency), 8'(k % 4));
      step();
    end
    btn_speed = 1'b1;
    repeat (20) step();
    btn_speed = 1'b0;
    step();
    check("speed_hold", 8'(bus.frequency), 8'd2);
    check("speed_no_blank", 8'(bus.enable), 8'd5);

    repeat (4) press_next();
    wait_enable(3'd4, 20);
    rst = 1'b1;
    btn_next = 1'b1;
    step();
    rst = 1'b0;
    cyc = 0;
    check("mid_rst_idx", 8'(bus.effect_idx), 8'd1);
    check("mid_rst_freq", 8'(bus.frequency), 8'd0);
    check("mid_rst_en", 8'(bus.enable), 8'd0);
    check("mid_rst_trans", 8'(bus.trans), 8'h7F);
    goto(8);
    check("held_btn_idx", 8'(bus.effect_idx), 8'd1);
    check("held_btn_en", 8'(bus.enable), 8'd1);
    btn_next = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
